// File: rtl/clkph_pkg.sv
// Shared definitions for the multiphase clock generator.
//
// Contents:
//   CLKPH_NPH / CLKPH_M / CLKPH_DIV_W  default phase count, ring width, prescaler width
//   ring_t, sel_t                      ring-state and phase-select types at the defaults
//   RING_ZERO                          all-zero ring state (parked / frame state)
//   ring_legal()                       true when a ring state is one of the 2*M Johnson codes
package clkph_pkg;

    localparam int CLKPH_NPH   = 8;
    localparam int CLKPH_M     = CLKPH_NPH / 2;
    localparam int CLKPH_DIV_W = 8;

    // Widest ring the legality check handles; narrower rings are zero-extended.
    localparam int RING_MAX_W  = 32;

    typedef logic [CLKPH_M-1:0]           ring_t;
    typedef logic [$clog2(CLKPH_NPH)-1:0] sel_t;

    localparam logic [RING_MAX_W-1:0] RING_ZERO = '0;

    // A Johnson code has at most one place where adjacent bits differ.
    // Only bits [m-1:0] of r are examined.
    function automatic logic ring_legal(input logic [RING_MAX_W-1:0] r, input int m);
        int edges;
        edges = 0;
        for (int i = 0; i < RING_MAX_W - 1; i++) begin
            if ((i + 1 < m) && (r[i] != r[i+1])) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/johnson_ring.sv
// Johnson (twisted-ring) counter of M flops: 2*M states, one bit changes per step.
//
// Ports:
//   clk     in  1   clock, rising edge
//   rst_n   in  1   synchronous reset, active low; clears the ring to all zeros
//   step_i  in  1   advance one state
//   clr_i   in  1   force the ring to all zeros (has priority over step_i)
//   q_o     out M   ring state
module johnson_ring #(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_i,
    input  logic         clr_i,
    output logic [M-1:0] q_o
);

    logic [M-1:0] q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr_i) begin
            q <= '0;
        end else if (step_i) begin
            q <= {q[M-2:0], ~q[M-1]};
        end
    end

    assign q_o = q;

endmodule

// File: rtl/multiphase_clk_gen.sv
// N-phase divided-clock generator. An M = NPH/2 bit Johnson ring gives NPH
// 50%-duty phases spaced 360/NPH degrees apart; the ring advances once every
// div+1 clocks, so each phase has a period of NPH*(div+1) clocks.
//
// Ports:
//   clk        in  1          clock, rising edge
//   rst_n      in  1          synchronous reset, active low
//   en_i       in  1          run request (level)
//   div_i      in  DIV_W      prescale value, taken at start and at each frame
//   sel_i      in  SEL_W      phase routed to clk_sel_o, taken at start and at each frame
//   ph_o       out NPH        all phases; ph_o[k]=j[k], ph_o[k+M]=~j[k]
//   clk_sel_o  out 1          registered selected phase, aligned with ph_o
//   frame_o    out 1          one-cycle pulse after the ring steps into state 0
//   running_o  out 1          generator active
//   err_o      out 1          one-cycle pulse when an illegal ring state was corrected
//
// Build option: define CLKPH_SELF_CORRECT_EN to enable the illegal-state
// check; without it err_o is tied low and illegal states recirculate.
module multiphase_clk_gen
    import clkph_pkg::*;
#(
    parameter int NPH   = CLKPH_NPH,
    parameter int DIV_W = CLKPH_DIV_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [DIV_W-1:0]       div_i,
    input  logic [$clog2(NPH)-1:0] sel_i,
    output logic [NPH-1:0]         ph_o,
    output logic                   clk_sel_o,
    output logic                   frame_o,
    output logic                   running_o,
    output logic                   err_o
);

    localparam int M     = NPH / 2;
    localparam int SEL_W = $clog2(NPH);
    localparam logic [M-1:0] RING_LAST = {1'b1, {(M-1){1'b0}}};

    // IDLE: parked at state 0. RUN: stepping with en_i high.
    // DRAIN: en_i dropped, finishing the current period before parking.
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} run_state_t;

    run_state_t       state, state_next;
    logic [M-1:0]     j, j_next;
    logic [DIV_W-1:0] pcnt, div_lat;
    logic [SEL_W-1:0] sel_lat, sel_in, sel_next;
    logic [NPH-1:0]   ph_next;
    logic             running, tick, at_zero, at_last;
    logic             step, wrap, stop, load, corr;

    johnson_ring #(.M(M)) u_ring (
        .clk    (clk),
        .rst_n  (rst_n),
        .step_i (step),
        .clr_i  (corr),
        .q_o    (j)
    );

    assign running = (state != ST_IDLE);
    assign tick    = (pcnt == div_lat);
    assign at_zero = (j == RING_ZERO[M-1:0]);
    assign at_last = (j == RING_LAST);

`ifdef CLKPH_SELF_CORRECT_EN
    assign corr = !ring_legal(RING_MAX_W'(j), M);
`else
    assign corr = 1'b0;
`endif

    // Parked at state 0 with en_i low: hold there instead of starting a new period.
    assign step = running & tick & ~corr & ~(~en_i & at_zero);
    assign wrap = step & at_last;
    assign stop = running & ~en_i & (at_zero | wrap);
    // Divider and select only change between periods, so no runt pulses.
    assign load = ~running | wrap;

    // Out-of-range selects (non-power-of-2 NPH) fall back to phase 0.
    assign sel_in   = ({1'b0, sel_i} < (SEL_W+1)'(NPH)) ? sel_i : '0;
    assign sel_next = load ? sel_in : sel_lat;

    always_comb begin
        j_next = j;
        if (corr) begin
            j_next = '0;
        end else if (step) begin
            j_next = {j[M-2:0], ~j[M-1]};
        end
    end

    assign ph_next = {~j_next, j_next};
    assign ph_o    = {~j, j};

    always_comb begin
        state_next = state;
        // A correction cycle leaves the run state alone.
        if (!corr) begin
            case (state)
                ST_IDLE:  if (en_i) state_next = ST_RUN;
                ST_RUN:   if (stop) state_next = ST_IDLE;
                          else if (!en_i) state_next = ST_DRAIN;
                ST_DRAIN: if (stop) state_next = ST_IDLE;
                          else if (en_i) state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pcnt      <= '0;
            div_lat   <= '0;
            sel_lat   <= '0;
            frame_o   <= 1'b0;
            clk_sel_o <= 1'b0;
        end else begin
            state <= state_next;
            if (corr || !running || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + DIV_W'(1);
            end
            if (load) begin
                div_lat <= div_i;
                sel_lat <= sel_in;
            end
            frame_o   <= wrap;
            clk_sel_o <= ph_next[sel_next];
        end
    end

    assign running_o = running;

`ifdef CLKPH_SELF_CORRECT_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= corr;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
